// File: rtl/eae_seq_unit.sv
// Multi-cycle PDP-8 Extended Arithmetic Element: MUL, DVI, NMI, SHL, ASR and LSR
// on the {AC,MQ} pair, one bit per clock, with a start/done handshake.
module eae_seq_unit #(
    parameter int WIDTH    = 12,
    parameter int SC_WIDTH = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [WIDTH-1:0]    ac_in,
    input  logic [WIDTH-1:0]    mq_in,
    input  logic                link_in,
    input  logic [WIDTH-1:0]    operand,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    ac_out,
    output logic [WIDTH-1:0]    mq_out,
    output logic                link_out,
    output logic [SC_WIDTH-1:0] sc_out
);

    // Step counter must hold both WIDTH (MUL/DVI) and the largest shift count.
    localparam int CNT_W = (SC_WIDTH > $clog2(WIDTH + 1)) ? SC_WIDTH : $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
    localparam logic [SC_WIDTH-1:0] SC_ONE  = SC_WIDTH'(1);

    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_DVI = 3'd2;
    localparam logic [2:0] OP_NMI = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_ASR = 3'd5;
    localparam logic [2:0] OP_LSR = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [2:0]          op_reg, op_next;
    logic [WIDTH-1:0]    opd_reg, opd_next;
    logic [WIDTH-1:0]    ac_reg, ac_next;
    logic [WIDTH-1:0]    mq_reg, mq_next;
    logic                link_reg, link_next;
    logic                sign_reg, sign_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [SC_WIDTH-1:0] sc_reg, sc_next;

    logic                last;
    logic                nmi_stop_now;
    logic                is_shift;
    logic [CNT_W-1:0]    shift_cnt;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_rem;
    logic                div_q;

    assign nmi_stop_now = (ac_reg[WIDTH-1] != ac_reg[WIDTH-2]) ||
                          ({ac_reg[WIDTH-3:0], mq_reg} == '0);
    assign is_shift     = (op == OP_SHL) || (op == OP_ASR) || (op == OP_LSR);
    assign shift_cnt    = CNT_W'(operand[SC_WIDTH-1:0]);

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        opd_next   = opd_reg;
        ac_next    = ac_reg;
        mq_next    = mq_reg;
        link_next  = link_reg;
        sign_next  = sign_reg;
        cnt_next   = cnt_reg;
        sc_next    = sc_reg;
        last       = 1'b0;
        mul_sum    = '0;
        div_rem    = '0;
        div_q      = 1'b0;

        case (state_reg)
            RUN: begin
                if (op_reg == OP_NMI) begin
                    // Stop test before each shift; re-test the shifted value so the
                    // final shift and the completion share one edge.
                    if (nmi_stop_now) begin
                        last = 1'b1;
                    end else begin
                        {ac_next, mq_next} = {ac_reg[WIDTH-2:0], mq_reg, 1'b0};
                        sc_next = sc_reg + SC_ONE;
                        last = (ac_next[WIDTH-1] != ac_next[WIDTH-2]) ||
                               ({ac_next[WIDTH-3:0], mq_next} == '0);
                    end
                end else if (cnt_reg == '0) begin
                    last = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                    last     = (cnt_reg == CNT_ONE);
                    case (op_reg)
                        OP_MUL: begin
                            mul_sum = {1'b0, ac_reg} + (mq_reg[0] ? {1'b0, opd_reg} : '0);
                            ac_next = mul_sum[WIDTH:1];
                            mq_next = {mul_sum[0], mq_reg[WIDTH-1:1]};
                        end
                        OP_DVI: begin
                            div_rem = {ac_reg, mq_reg[WIDTH-1]};
                            if (div_rem >= {1'b0, opd_reg}) begin
                                div_rem = div_rem - {1'b0, opd_reg};
                                div_q   = 1'b1;
                            end
                            ac_next = div_rem[WIDTH-1:0];
                            mq_next = {mq_reg[WIDTH-2:0], div_q};
                        end
                        OP_SHL: begin
                            link_next = ac_reg[WIDTH-1];
                            {ac_next, mq_next} = {ac_reg[WIDTH-2:0], mq_reg, 1'b0};
                        end
                        OP_ASR: {ac_next, mq_next} = {sign_reg, ac_reg, mq_reg[WIDTH-1:1]};
                        OP_LSR: {ac_next, mq_next} = {1'b0, ac_reg, mq_reg[WIDTH-1:1]};
                        default: ;
                    endcase
                end
                if (last) state_next = DONE;
            end
            default: begin
                if (state_reg == DONE) state_next = IDLE;
                if (start) begin
                    state_next = RUN;
                    op_next    = op;
                    opd_next   = operand;
                    ac_next    = ac_in;
                    mq_next    = mq_in;
                    sign_next  = ac_in[WIDTH-1];
                    sc_next    = '0;
                    cnt_next   = '0;
                    link_next  = link_in;
                    if (op == OP_MUL) begin
                        cnt_next  = CNT_W'(WIDTH);
                        link_next = 1'b0;
                    end else if (op == OP_DVI) begin
                        // Overflow (including divide by zero) completes with zero steps.
                        link_next = (ac_in >= operand);
                        cnt_next  = (ac_in >= operand) ? '0 : CNT_W'(WIDTH);
                    end else if (is_shift && shift_cnt != '0) begin
                        cnt_next  = shift_cnt;
                        link_next = (op == OP_ASR) ? ac_in[WIDTH-1] : 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            opd_reg   <= '0;
            ac_reg    <= '0;
            mq_reg    <= '0;
            link_reg  <= 1'b0;
            sign_reg  <= 1'b0;
            cnt_reg   <= '0;
            sc_reg    <= '0;
            ac_out    <= '0;
            mq_out    <= '0;
            link_out  <= 1'b0;
            sc_out    <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            opd_reg   <= opd_next;
            ac_reg    <= ac_next;
            mq_reg    <= mq_next;
            link_reg  <= link_next;
            sign_reg  <= sign_next;
            cnt_reg   <= cnt_next;
            sc_reg    <= sc_next;
            if (state_reg == RUN && last) begin
                ac_out   <= ac_next;
                mq_out   <= mq_next;
                link_out <= link_next;
                sc_out   <= (op_reg == OP_NMI) ? sc_next : '0;
            end
        end
    end

endmodule

// File: tb/tb_eae_seq_unit.sv
// Directed bench for eae_seq_unit: a table of single operations with hand-computed
// results and latencies, plus sequences for ignored start, back-to-back and reset abort.
module tb_eae_seq_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [11:0] ac_in, mq_in, operand;
    logic        link_in;
    logic        busy, done;
    logic [11:0] ac_out, mq_out;
    logic        link_out;
    logic [4:0]  sc_out;

    int n_checks = 0;
    int n_fail   = 0;

    eae_seq_unit #(.WIDTH(12), .SC_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .ac_in(ac_in), .mq_in(mq_in), .link_in(link_in), .operand(operand),
        .busy(busy), .done(done), .ac_out(ac_out), .mq_out(mq_out),
        .link_out(link_out), .sc_out(sc_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] ac;
        logic [11:0] mq;
        logic        link;
        logic [11:0] opd;
        logic [11:0] e_ac;
        logic [11:0] e_mq;
        logic        e_link;
        logic [4:0]  e_sc;
        int          e_lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [11:0] a, input logic [11:0] m,
                         input logic l, input logic [11:0] d);
        op = o; ac_in = a; mq_in = m; link_in = l; operand = d;
    endtask

    // Counts edges after the current one until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        string tag;

        vecs[0]  = '{3'd1, 12'o0005, 12'o0012, 1'b1, 12'o0003, 12'o0000, 12'o0043, 1'b0, 5'd0, 12};
        vecs[1]  = '{3'd2, 12'o0001, 12'o0000, 1'b1, 12'o0003, 12'o0001, 12'o2525, 1'b0, 5'd0, 12};
        vecs[2]  = '{3'd2, 12'o0005, 12'o1234, 1'b0, 12'o0003, 12'o0005, 12'o1234, 1'b1, 5'd0, 1};
        vecs[3]  = '{3'd2, 12'o0000, 12'o0777, 1'b0, 12'o0000, 12'o0000, 12'o0777, 1'b1, 5'd0, 1};
        vecs[4]  = '{3'd3, 12'o0000, 12'o0400, 1'b1, 12'o0000, 12'o2000, 12'o0000, 1'b1, 5'd14, 14};
        vecs[5]  = '{3'd3, 12'o0000, 12'o0000, 1'b0, 12'o0000, 12'o0000, 12'o0000, 1'b0, 5'd0, 1};
        vecs[6]  = '{3'd5, 12'o4000, 12'o0000, 1'b0, 12'o0003, 12'o7400, 12'o0000, 1'b1, 5'd0, 3};
        vecs[7]  = '{3'd6, 12'o4000, 12'o0000, 1'b1, 12'o0003, 12'o0400, 12'o0000, 1'b0, 5'd0, 3};
        vecs[8]  = '{3'd4, 12'o4001, 12'o0000, 1'b0, 12'o0001, 12'o0002, 12'o0000, 1'b1, 5'd0, 1};
        vecs[9]  = '{3'd0, 12'o1234, 12'o4321, 1'b1, 12'o0017, 12'o1234, 12'o4321, 1'b1, 5'd0, 1};
        vecs[10] = '{3'd7, 12'o1234, 12'o4321, 1'b0, 12'o0017, 12'o1234, 12'o4321, 1'b0, 5'd0, 1};
        vecs[11] = '{3'd4, 12'o4001, 12'o0000, 1'b0, 12'o0000, 12'o4001, 12'o0000, 1'b0, 5'd0, 1};
        vecs[12] = '{3'd1, 12'o7777, 12'o7777, 1'b1, 12'o7777, 12'o7777, 12'o0000, 1'b0, 5'd0, 12};
        vecs[13] = '{3'd6, 12'o7777, 12'o7777, 1'b1, 12'o0037, 12'o0000, 12'o0000, 1'b0, 5'd0, 31};
        vecs[14] = '{3'd5, 12'o4000, 12'o0001, 1'b0, 12'o0036, 12'o7777, 12'o7777, 1'b1, 5'd0, 30};
        vecs[15] = '{3'd3, 12'o2000, 12'o0000, 1'b0, 12'o0000, 12'o2000, 12'o0000, 1'b0, 5'd0, 1};
        vecs[16] = '{3'd3, 12'o7777, 12'o7777, 1'b0, 12'o0000, 12'o6000, 12'o0000, 1'b0, 5'd22, 22};
        vecs[17] = '{3'd2, 12'o1234, 12'o5670, 1'b1, 12'o4000, 12'o1670, 12'o2471, 1'b0, 5'd0, 12};
        vecs[18] = '{3'd4, 12'o4001, 12'o4000, 1'b0, 12'o0002, 12'o0006, 12'o0000, 1'b0, 5'd0, 2};

        reset = 1'b1; start = 1'b0;
        drive(3'd0, '0, '0, 1'b0, '0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ac",   ac_out, 0);
        check("reset_mq",   mq_out, 0);
        check("reset_link", link_out, 0);
        check("reset_sc",   sc_out, 0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(vecs[i].op, vecs[i].ac, vecs[i].mq, vecs[i].link, vecs[i].opd);
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            tag = $sformatf("v%0d_", i);
            check({tag, "busy0"}, busy, 1);
            wait_done(lat);
            check({tag, "latency"}, lat, vecs[i].e_lat);
            check({tag, "ac"},   ac_out,   vecs[i].e_ac);
            check({tag, "mq"},   mq_out,   vecs[i].e_mq);
            check({tag, "link"}, link_out, vecs[i].e_link);
            check({tag, "sc"},   sc_out,   vecs[i].e_sc);
            check({tag, "busy_at_done"}, busy, 0);
            @(posedge clock); #1;
            check({tag, "done_pulse"}, done, 0);
            $display("op=%0d ac=%o mq=%o opd=%o -> ac=%o mq=%o link=%0d sc=%0d lat=%0d",
                     vecs[i].op, vecs[i].ac, vecs[i].mq, vecs[i].opd,
                     ac_out, mq_out, link_out, sc_out, lat);
        end

        // Back-to-back: second start held during the DONE cycle of a 3-count LSR.
        @(negedge clock);
        drive(3'd6, 12'o4000, 12'o0000, 1'b0, 12'o0003);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(lat);
        check("b2b_lat1", lat, 3);
        check("b2b_ac1", ac_out, 12'o0400);
        drive(3'd1, 12'o0005, 12'o0012, 1'b0, 12'o0003);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done_low", done, 0);
        wait_done(lat);
        check("b2b_lat2", lat, 12);
        check("b2b_mq2", mq_out, 12'o0043);
        @(posedge clock); #1;
        check("b2b_done_pulse", done, 0);
        $display("back-to-back LSR then MUL -> mq=%o lat=%0d", mq_out, lat);

        // A start while busy is ignored and never queued.
        @(negedge clock);
        drive(3'd1, 12'o0005, 12'o0012, 1'b0, 12'o0003);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        drive(3'd6, 12'o7777, 12'o7777, 1'b0, 12'o0001);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(lat);
        check("ign_lat", lat, 9);
        check("ign_ac", ac_out, 12'o0000);
        check("ign_mq", mq_out, 12'o0043);
        seen = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done === 1'b1) seen++;
        end
        check("ign_no_extra_done", seen, 0);
        $display("ignored start during MUL -> mq=%o extra_done=%0d", mq_out, seen);

        // Reset mid-operation: second start at edge 3, reset at edge 5.
        @(negedge clock);
        drive(3'd1, 12'o0005, 12'o0012, 1'b0, 12'o0003);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("rst_busy_e3", busy, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ac", ac_out, 0);
        check("rst_mq", mq_out, 0);
        check("rst_link", link_out, 0);
        check("rst_sc", sc_out, 0);
        seen = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done === 1'b1) seen++;
        end
        check("rst_no_done", seen, 0);
        $display("reset abort -> busy=%0d mq=%o done_after=%0d", busy, mq_out, seen);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
